// File: rtl/click_gesture_decoder.sv
// Turns short/long press pulses into single, double and long click pulses using a
// multi-click window; triple click is decoded only when CLICK_TRIPLE_EN is defined.
module click_gesture_decoder #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int WINDOW_MS = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic short_press_event,
  input  logic long_press_event,
  output logic single_click,
  output logic double_click,
  output logic triple_click,
  output logic long_click,
  output logic busy
);

  // state | meaning
  // IDLE  | no gesture in progress
  // WAIT2 | one short press held, window open for the next one
  // WAIT3 | two short presses held, window open (CLICK_TRIPLE_EN only)

  localparam int W  = (CLK_FREQ / 1000) * WINDOW_MS;
  localparam int TW = $clog2(W);
  localparam logic [TW-1:0] TIMER_LAST = TW'(W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT2 = 2'd1;
`ifdef CLICK_TRIPLE_EN
  localparam logic [1:0] WAIT3 = 2'd2;
`endif

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          timer_done;

  assign timer_done = (timer == TIMER_LAST);
  assign busy       = (state != IDLE);

`ifndef CLICK_TRIPLE_EN
  assign triple_click = 1'b0;
`endif

  // Long press always wins over a coincident short press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_click   <= 1'b0;
`ifdef CLICK_TRIPLE_EN
      triple_click <= 1'b0;
`endif
    end else begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_click   <= 1'b0;
`ifdef CLICK_TRIPLE_EN
      triple_click <= 1'b0;
`endif
      if (!timer_done) timer <= timer + TW'(1);

      case (state)
        IDLE: begin
          timer <= '0;
          if (long_press_event) begin
            long_click <= 1'b1;
          end else if (short_press_event) begin
            state <= WAIT2;
          end
        end

        WAIT2: begin
          if (long_press_event) begin
            single_click <= 1'b1;
            long_click   <= 1'b1;
            state        <= IDLE;
            timer        <= '0;
          end else if (short_press_event) begin
`ifdef CLICK_TRIPLE_EN
            state <= WAIT3;
            timer <= '0;
`else
            double_click <= 1'b1;
            state        <= IDLE;
            timer        <= '0;
`endif
          end else if (timer_done) begin
            single_click <= 1'b1;
            state        <= IDLE;
            timer        <= '0;
          end
        end

`ifdef CLICK_TRIPLE_EN
        WAIT3: begin
          if (long_press_event) begin
            double_click <= 1'b1;
            long_click   <= 1'b1;
            state        <= IDLE;
            timer        <= '0;
          end else if (short_press_event) begin
            triple_click <= 1'b1;
            state        <= IDLE;
            timer        <= '0;
          end else if (timer_done) begin
            double_click <= 1'b1;
            state        <= IDLE;
            timer        <= '0;
          end
        end
`endif

        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_click_gesture_decoder.sv
// Scoreboard bench for click_gesture_decoder with W = 10 cycles; expectations follow
// CLICK_TRIPLE_EN when it is defined for the build.
module tb_click_gesture_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic short_press_event = 1'b0;
  logic long_press_event = 1'b0;
  logic single_click, double_click, triple_click, long_click, busy;

  localparam logic [3:0] L  = 4'b0001;
  localparam logic [3:0] S  = 4'b0010;
  localparam logic [3:0] D  = 4'b0100;
  localparam logic [3:0] TR = 4'b1000;

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [3:0] obs_v, exp_v;

  click_gesture_decoder #(.CLK_FREQ(1000), .WINDOW_MS(10)) dut (
    .clk               (clk),
    .reset             (reset),
    .short_press_event (short_press_event),
    .long_press_event  (long_press_event),
    .single_click      (single_click),
    .double_click      (double_click),
    .triple_click      (triple_click),
    .long_click        (long_click),
    .busy              (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle the output vector must equal the scheduled pulse, or all zero.
  always @(negedge clk) begin
    if (mon_en) begin
      obs_v = {triple_click, double_click, single_click, long_click};
      exp_v = 4'b0000;
      if (q.size() != 0 && q[0].cyc == cyc) begin
        exp_v = q[0].v;
        void'(q.pop_front());
      end
      checks++;
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL outputs cyc=%0d observed=%b expected=%b", cyc, obs_v, exp_v);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic s, input logic l);
    short_press_event = s;
    long_press_event  = l;
    @(posedge clk);
    #1;
    short_press_event = 1'b0;
    long_press_event  = 1'b0;
  endtask

  task automatic expect_at(input int c, input logic [3:0] v);
    q.push_back('{c, v});
  endtask

  task automatic chk_busy(input logic e, input string tag);
    checks++;
    assert (busy === e) else begin
      errors++;
      $error("FAIL busy_%s cyc=%0d observed=%b expected=%b", tag, cyc, busy, e);
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (q.size() != 0 && k < 60) begin
      idle(1);
      k++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain_%s observed=%0d pending expected=0", tag, q.size());
    end
    idle(3);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    chk_busy(1'b0, "reset");
    idle(2);

    // single click and busy window
    t = cyc;
    expect_at(t + 11, S);
    press(1'b1, 1'b0);
    chk_busy(1'b1, "single_first");
    idle(9);
    chk_busy(1'b1, "single_last");
    idle(1);
    chk_busy(1'b0, "single_after");
    drain("single");

    // second short 5 cycles later
    t = cyc;
    press(1'b1, 1'b0);
    idle(4);
`ifdef CLICK_TRIPLE_EN
    expect_at(t + 16, D);
`else
    expect_at(t + 6, D);
`endif
    press(1'b1, 1'b0);
    drain("double");

    // second short on the last window cycle wins over timeout
    t = cyc;
    press(1'b1, 1'b0);
    idle(9);
`ifdef CLICK_TRIPLE_EN
    expect_at(t + 21, D);
`else
    expect_at(t + 11, D);
`endif
    press(1'b1, 1'b0);
    drain("edge10");

    // one cycle too late: single, then the late short opens a new window
    t = cyc;
    expect_at(t + 11, S);
    press(1'b1, 1'b0);
    idle(10);
    expect_at(t + 22, S);
    press(1'b1, 1'b0);
    chk_busy(1'b1, "edge11_reopen");
    drain("edge11");

    // long from idle
    t = cyc;
    expect_at(t + 1, L);
    press(1'b0, 1'b1);
    chk_busy(1'b0, "long_idle");
    drain("long");

    // long inside the window
    t = cyc;
    expect_at(t + 5, S | L);
    press(1'b1, 1'b0);
    idle(3);
    press(1'b0, 1'b1);
    drain("long_window");

    // simultaneous short and long in idle: long only
    t = cyc;
    expect_at(t + 1, L);
    press(1'b1, 1'b1);
    chk_busy(1'b0, "simul");
    drain("simul");

    // back-to-back longs, second arrives while first pulse is driven
    t = cyc;
    expect_at(t + 1, L);
    press(1'b0, 1'b1);
    expect_at(t + 2, L);
    press(1'b0, 1'b1);
    drain("b2b");

`ifdef CLICK_TRIPLE_EN
    t = cyc;
    expect_at(t + 10, TR);
    press(1'b1, 1'b0);
    idle(4);
    press(1'b1, 1'b0);
    idle(3);
    press(1'b1, 1'b0);
    drain("triple");

    t = cyc;
    expect_at(t + 5, D | L);
    press(1'b1, 1'b0);
    idle(1);
    press(1'b1, 1'b0);
    idle(1);
    press(1'b0, 1'b1);
    drain("long_wait3");
`endif

    // reset discards a pending click
    t = cyc;
    press(1'b1, 1'b0);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk_busy(1'b0, "reset_mid");
    idle(20);
    chk_busy(1'b0, "reset_after");
    drain("reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "bench timed out");
  end

endmodule
